// File: rtl/mux_4_32_rr_ctrl.sv
// Round-robin select/enable controller for the 4:1 32-bit mux; grants bursts of up to MAX_BURST beats.
// Optional feature: define MUX_ARB_PARK_EN to keep the bus parked on the last grantee while idle.
module mux_4_32_rr_ctrl #(
    parameter int MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] select,
    output logic       enable,
    output logic [3:0] grant,
    output logic       burst_done
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q;
    logic [1:0]       select_q;
    logic             enable_q;
    logic [3:0]       grant_q;
    logic             burst_done_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [1:0]       rr_ptr_q;

    logic             beat;
    logic             release_now;
    logic [1:0]       ptr_eff;
    logic [1:0]       select_d;
    logic [3:0]       grant_d;
    logic             idle_enable_d;

    // First set request above ptr (wrapping); ptr itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

`ifdef MUX_ARB_PARK_EN
    logic parked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parked_q <= 1'b0;
        end else if (state_q == IDLE && |req) begin
            parked_q <= 1'b1;
        end
    end

    assign idle_enable_d = parked_q;
`else
    assign idle_enable_d = 1'b0;
`endif

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        beat        = enable_q & out_ready & (state_q == GRANT);
        release_now = (state_q == GRANT) &
                      ((beat & (beat_cnt_q == LAST_BEAT)) | ~req[select_q]);
        // The released source becomes lowest priority for the back-to-back regrant.
        ptr_eff     = release_now ? select_q : rr_ptr_q;
        select_d    = rr_pick(req, ptr_eff);
        grant_d     = 4'b0001 << select_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            select_q     <= 2'd0;
            enable_q     <= 1'b0;
            grant_q      <= 4'b0000;
            burst_done_q <= 1'b0;
            beat_cnt_q   <= '0;
            rr_ptr_q     <= 2'd3;
        end else begin
            burst_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q    <= GRANT;
                        select_q   <= select_d;
                        grant_q    <= grant_d;
                        enable_q   <= 1'b1;
                        beat_cnt_q <= '0;
                    end else begin
                        grant_q  <= 4'b0000;
                        enable_q <= idle_enable_d;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        rr_ptr_q     <= select_q;
                        burst_done_q <= 1'b1;
                        beat_cnt_q   <= '0;
                        if (|req) begin
                            select_q <= select_d;
                            grant_q  <= grant_d;
                            enable_q <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                            grant_q  <= 4'b0000;
                            enable_q <= idle_enable_d;
                        end
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign select     = select_q;
    assign enable     = enable_q;
    assign grant      = grant_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_mux_4_32_rr_ctrl.sv
// Scoreboard bench for mux_4_32_rr_ctrl: directed scenarios then random traffic against a transaction-level model.
module tb_mux_4_32_rr_ctrl;

    localparam int MAX_BURST = 8;
`ifdef MUX_ARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic [3:0] gnt;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] select;
    logic       enable;
    logic [3:0] grant;
    logic       burst_done;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    // Model state: who owns the bus (-1 = nobody), beats taken, last released owner.
    int         m_owner;
    int         m_beats;
    int         m_last;
    bit         m_ever;
    logic [1:0] m_sel;

    mux_4_32_rr_ctrl #(.MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .out_ready  (out_ready),
        .select     (select),
        .enable     (enable),
        .grant      (grant),
        .burst_done (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
        n_checks++;
        if (act !== req_val) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req_val, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = 3;
        m_ever  = 1'b0;
        m_sel   = 2'd0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic rdy, output exp_t e);
        int idx;
        e.done = 1'b0;
        if (m_owner >= 0) begin
            if (rdy) m_beats++;
            if (m_beats == MAX_BURST || !r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_beats = 0;
                e.done  = 1'b1;
            end
        end
        if (m_owner < 0 && r != 4'b0000) begin
            for (int off = 1; off <= 4; off++) begin
                idx = (m_last + off) % 4;
                if (m_owner < 0 && r[idx]) m_owner = idx;
            end
            m_beats = 0;
            m_ever  = 1'b1;
            m_sel   = m_owner[1:0];
        end
        e.sel = m_sel;
        e.en  = (m_owner >= 0) || (PARK && m_ever);
        e.gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    endtask

    // Drive inputs for the coming edge and queue what the DUT must show after it.
    task automatic step(input logic [3:0] r, input logic rdy);
        exp_t e;
        req       = r;
        out_ready = rdy;
        model_step(r, rdy, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_t e;
        e         = '0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        exp_q.delete();
        model_reset();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [3:0] r, input logic rdy, input int cycles);
        for (int i = 0; i < cycles; i++) step(r, rdy);
    endtask

    // Monitor: compares the DUT outputs each cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("select", 32'(select), 32'(e.sel));
                check("enable", 32'(enable), 32'(e.en));
                check("grant", 32'(grant), 32'(e.gnt));
                check("burst_done", 32'(burst_done), 32'(e.done));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r;
        logic       rdy;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Single requester: grant after one cycle, regrant at the burst limit without a bubble.
        do_reset();
        run(4'b0001, 1'b1, 20);

        // All requesters: rotation 0,1,2,3,0 every MAX_BURST beats.
        do_reset();
        run(4'b1111, 1'b1, 5 * MAX_BURST + 4);

        // Grant on 2, drop its request after 3 beats: next grant goes to 3, not 0.
        do_reset();
        run(4'b0100, 1'b1, 4);
        run(4'b1001, 1'b1, 6);

        // Grant on 1 with out_ready low for 20 cycles, then the remaining beats.
        do_reset();
        run(4'b0010, 1'b1, 1);
        run(4'b0010, 1'b0, 20);
        run(4'b0010, 1'b1, 10);

        // Reset in the middle of a burst, then restart at req[0] priority.
        do_reset();
        run(4'b1111, 1'b1, 4);
        do_reset();
        run(4'b1100, 1'b1, 4);

        // Burst on 3 then requests vanish: idle behaviour of enable/select.
        do_reset();
        run(4'b1000, 1'b1, 10);
        run(4'b0000, 1'b1, 4);

        // Randomized traffic with sticky requests and a bursty out_ready.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                r = 4'b0000;
            end
            if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rdy);
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
